retire_trace_pipe: RTL and testbench

Parametrised shadow pipeline for the verification environment. It captures per-instruction metadata (pc, instr, format one-hot, rd/rs1/rs2) at issue and carries it through a configurable number of stages. Each record stays aligned with the core's retire strobe, honouring stall and per-stage flush. It emits one aligned retire record per retired instruction, counts retirements, raises done at a programmable limit, and flags any retire/trace misalignment.

---
 rtl/retire_trace_pipe_pkg.sv | 34 +++
 rtl/retire_trace_pipe_stage.sv | 47 ++++
 rtl/retire_trace_pipe.sv | 143 ++++++++++++++
 tb/tb_retire_trace_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pipe_pkg.sv
// Shared types and constants for the retire trace shadow pipeline:
// record layout, instruction-format one-hot bits and error cause codes.
package trace_pkg;

    localparam int TR_XLEN  = 32;
    localparam int TR_REG_W = 5;

    // Field order matches the flat payload packing used inside the pipe.
    typedef struct packed {
        logic [TR_XLEN-1:0]  pc;
        logic [TR_XLEN-1:0]  instr;
        logic [5:0]          rtype;
        logic [TR_REG_W-1:0] rd;
        logic [TR_REG_W-1:0] rs1;
        logic [TR_REG_W-1:0] rs2;
    } trace_rec_t;

    localparam logic [5:0] TYPE_R = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_B = 6'b001000;
    localparam logic [5:0] TYPE_U = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NO_TRACE  = 2'b01;
    localparam logic [1:0] ERR_NO_RETIRE = 2'b10;
    localparam logic [1:0] ERR_BAD_TYPE  = 2'b11;

    function automatic logic is_onehot6(input logic [5:0] t);
        return (t != 6'd0) && ((t & (t - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/retire_trace_pipe_stage.sv
// One shadow-pipe slice: a reset valid bit plus an unreset payload.
// Flush beats load; when load is low the slice holds.
module trace_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/retire_trace_pipe.sv
// Shadow pipeline carrying issue-time metadata to the retire point, with
// retire/trace alignment checking, a saturating retire counter and done flag.
module retire_trace_pipe
    import trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_INSTR = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_valid_i,
    input  logic [XLEN-1:0]   cap_pc_i,
    input  logic [XLEN-1:0]   cap_instr_i,
    input  logic [5:0]        cap_type_i,
    input  logic [REG_W-1:0]  cap_rd_i,
    input  logic [REG_W-1:0]  cap_rs1_i,
    input  logic [REG_W-1:0]  cap_rs2_i,
    input  logic              stall_i,
    input  logic [STAGES-1:0] flush_i,
    input  logic              retired_i,
    output logic              ret_valid_o,
    output logic [XLEN-1:0]   ret_pc_o,
    output logic [XLEN-1:0]   ret_instr_o,
    output logic [5:0]        ret_type_o,
    output logic [REG_W-1:0]  ret_rd_o,
    output logic [REG_W-1:0]  ret_rs1_o,
    output logic [REG_W-1:0]  ret_rs2_o,
    output logic [CNT_W-1:0]  instr_count_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned REC_W = 2 * XLEN + 6 + 3 * REG_W;

    logic [STAGES-1:0] in_valid;
    logic [REC_W-1:0]  in_data  [STAGES];
    logic [STAGES-1:0] st_valid;
    logic [REC_W-1:0]  st_data  [STAGES];

    assign in_valid[0] = cap_valid_i;
    assign in_data[0]  = {cap_pc_i, cap_instr_i, cap_type_i, cap_rd_i, cap_rs1_i, cap_rs2_i};

    // A record killed in stage k-1 on a shift edge becomes a bubble in stage k.
    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_link
            assign in_valid[gi] = st_valid[gi-1] & ~flush_i[gi-1];
            assign in_data[gi]  = st_data[gi-1];
        end

        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            trace_stage #(
                .W (REC_W)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .load_i  (~stall_i),
                .flush_i (flush_i[gi]),
                .valid_i (in_valid[gi]),
                .data_i  (in_data[gi]),
                .valid_o (st_valid[gi]),
                .data_o  (st_data[gi])
            );
        end
    endgenerate

    logic tail_valid;

    assign tail_valid  = st_valid[STAGES-1];
    assign ret_valid_o = tail_valid & retired_i;
    assign {ret_pc_o, ret_instr_o, ret_type_o, ret_rd_o, ret_rs1_o, ret_rs2_o} = st_data[STAGES-1];

    logic             err_hit;
    logic [1:0]       err_cause;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             count_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    // Alignment is only meaningful while the core is advancing.
    always_comb begin
        err_hit   = 1'b0;
        err_cause = ERR_NONE;
        if (!stall_i) begin
            if (retired_i && !tail_valid) begin
                err_hit   = 1'b1;
                err_cause = ERR_NO_TRACE;
            end else if (tail_valid && !retired_i) begin
                err_hit   = 1'b1;
                err_cause = ERR_NO_RETIRE;
            end else if (ret_valid_o && !is_onehot6(ret_type_o)) begin
                err_hit   = 1'b1;
                err_cause = ERR_BAD_TYPE;
            end
        end
    end

    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (err_hit && !err_q) begin
            err_d      = 1'b1;
            err_code_d = err_cause;
        end
    end

    always_comb begin
        count_inc = ret_valid_o && (count_q != {CNT_W{1'b1}});
        count_d   = count_q;
        if (count_inc) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        done_d = done_q;
        if ((MAX_INSTR != 0) && count_inc && (count_d == CNT_W'(MAX_INSTR))) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    assign instr_count_o = count_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_retire_trace_pipe.sv
// Directed self-checking bench for retire_trace_pipe (STAGES=3, MAX_INSTR=5).
module tb_retire_trace_pipe;

    localparam int XLEN   = 32;
    localparam int STAGES = 3;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 32;
    localparam int MAXI   = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cap_valid_i;
    logic [XLEN-1:0]   cap_pc_i;
    logic [XLEN-1:0]   cap_instr_i;
    logic [5:0]        cap_type_i;
    logic [REG_W-1:0]  cap_rd_i, cap_rs1_i, cap_rs2_i;
    logic              stall_i;
    logic [STAGES-1:0] flush_i;
    logic              retired_i;
    logic              ret_valid_o;
    logic [XLEN-1:0]   ret_pc_o, ret_instr_o;
    logic [5:0]        ret_type_o;
    logic [REG_W-1:0]  ret_rd_o, ret_rs1_o, ret_rs2_o;
    logic [CNT_W-1:0]  instr_count_o;
    logic              done_o, err_o;
    logic [1:0]        err_code_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    retire_trace_pipe #(
        .XLEN(XLEN), .STAGES(STAGES), .REG_W(REG_W), .CNT_W(CNT_W), .MAX_INSTR(MAXI)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cap_valid_i(cap_valid_i), .cap_pc_i(cap_pc_i), .cap_instr_i(cap_instr_i),
        .cap_type_i(cap_type_i), .cap_rd_i(cap_rd_i), .cap_rs1_i(cap_rs1_i), .cap_rs2_i(cap_rs2_i),
        .stall_i(stall_i), .flush_i(flush_i), .retired_i(retired_i),
        .ret_valid_o(ret_valid_o), .ret_pc_o(ret_pc_o), .ret_instr_o(ret_instr_o),
        .ret_type_o(ret_type_o), .ret_rd_o(ret_rd_o), .ret_rs1_o(ret_rs1_o), .ret_rs2_o(ret_rs2_o),
        .instr_count_o(instr_count_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cap(input logic v, input logic [XLEN-1:0] pc, input logic [5:0] t);
        cap_valid_i = v;
        cap_pc_i    = pc;
        cap_instr_i = pc ^ 32'hA5A5_0000;
        cap_type_i  = t;
        cap_rd_i    = pc[6:2];
        cap_rs1_i   = pc[7:3];
        cap_rs2_i   = pc[8:4];
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        stall_i   = 1'b0;
        flush_i   = '0;
        retired_i = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        retired_i = 1'b1;
        #1;
        total_cnt++;
        if (ret_valid_o !== 1'b0) $display("FAIL reset_ret_valid: got %b expected 0", ret_valid_o);
        else pass_cnt++;
        retired_i = 1'b0;
        total_cnt++;
        if (instr_count_o !== 32'd0) $display("FAIL reset_count: got %0d expected 0", instr_count_o);
        else pass_cnt++;
        total_cnt++;
        if ({done_o, err_o, err_code_o} !== 4'b0000)
            $display("FAIL reset_flags: got done=%b err=%b code=%b expected all 0", done_o, err_o, err_code_o);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_cap(i < 3, 32'h2000 + 32'(4 * i), trace_pkg::TYPE_I);
            retired_i = (i >= 3);
            if (i >= 3) begin
                #1;
                total_cnt++;
                if (ret_valid_o !== 1'b1 || ret_pc_o !== 32'h2000 + 32'(4 * (i - 3)))
                    $display("FAIL b2b_retire%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                             i - 3, ret_valid_o, ret_pc_o, 32'h2000 + 32'(4 * (i - 3)));
                else pass_cnt++;
            end
            step(1);
        end
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        retired_i = 1'b0;
        step(1);
        total_cnt++;
        if (instr_count_o !== 32'd3) $display("FAIL b2b_count: got %0d expected 3", instr_count_o);
        else pass_cnt++;
        total_cnt++;
        if (err_o !== 1'b0) $display("FAIL b2b_err: got %b expected 0", err_o);
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_stall();
        do_reset();
        set_cap(1'b1, 32'h2000, trace_pkg::TYPE_B);
        step(1);
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        step(1);
        stall_i = 1'b1;
        set_cap(1'b1, 32'h3000, trace_pkg::TYPE_R);
        for (int i = 0; i < 4; i++) begin
            step(1);
            retired_i = 1'b1;
            #1;
            total_cnt++;
            if (ret_valid_o !== 1'b0) $display("FAIL stall_hold%0d: got valid=%b expected 0", i, ret_valid_o);
            else pass_cnt++;
            retired_i = 1'b0;
        end
        stall_i = 1'b0;
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        step(1);
        retired_i = 1'b1;
        #1;
        total_cnt++;
        if (ret_valid_o !== 1'b1 || ret_pc_o !== 32'h2000 || ret_instr_o !== (32'h2000 ^ 32'hA5A5_0000)
            || ret_type_o !== trace_pkg::TYPE_B)
            $display("FAIL stall_retire: got valid=%b pc=%h instr=%h type=%b expected 1 00002000 a5a52000 001000",
                     ret_valid_o, ret_pc_o, ret_instr_o, ret_type_o);
        else pass_cnt++;
        step(1);
        retired_i = 1'b0;
        step(3);
        total_cnt++;
        if (err_o !== 1'b0 || instr_count_o !== 32'd1)
            $display("FAIL stall_after: got err=%b count=%0d expected err=0 count=1", err_o, instr_count_o);
        else pass_cnt++;
        $display("test_stall done");
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_cap(1'b1, 32'h4000 + 32'(4 * i), trace_pkg::TYPE_S);
            step(1);
        end
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        flush_i   = 3'b011;
        retired_i = 1'b1;
        #1;
        total_cnt++;
        if (ret_valid_o !== 1'b1 || ret_pc_o !== 32'h4000)
            $display("FAIL flush_tail: got valid=%b pc=%h expected 1 00004000", ret_valid_o, ret_pc_o);
        else pass_cnt++;
        step(1);
        flush_i   = '0;
        retired_i = 1'b0;
        step(3);
        total_cnt++;
        if (err_o !== 1'b0) $display("FAIL flush_err: got %b expected 0", err_o);
        else pass_cnt++;
        total_cnt++;
        if (instr_count_o !== 32'd1) $display("FAIL flush_count: got %0d expected 1", instr_count_o);
        else pass_cnt++;
        $display("test_flush done");
    endtask

    task automatic test_err_codes();
        do_reset();
        retired_i = 1'b1;
        step(1);
        retired_i = 1'b0;
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 2'b01)
            $display("FAIL err_no_trace: got err=%b code=%b expected 1 01", err_o, err_code_o);
        else pass_cnt++;
        set_cap(1'b1, 32'h5000, trace_pkg::TYPE_U);
        step(1);
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        step(3);
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 2'b01)
            $display("FAIL err_sticky: got err=%b code=%b expected 1 01", err_o, err_code_o);
        else pass_cnt++;

        do_reset();
        set_cap(1'b1, 32'h6000, 6'b000011);
        step(1);
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        step(2);
        retired_i = 1'b1;
        #1;
        total_cnt++;
        if (ret_valid_o !== 1'b1 || ret_type_o !== 6'b000011)
            $display("FAIL badtype_rec: got valid=%b type=%b expected 1 000011", ret_valid_o, ret_type_o);
        else pass_cnt++;
        step(1);
        retired_i = 1'b0;
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 2'b11)
            $display("FAIL badtype_code: got err=%b code=%b expected 1 11", err_o, err_code_o);
        else pass_cnt++;
        $display("test_err_codes done");
    endtask

    task automatic test_done_and_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_cap(i < 7, 32'h7000 + 32'(4 * i), trace_pkg::TYPE_J);
            retired_i = (i >= 3);
            step(1);
            if (i >= 3) begin
                total_cnt++;
                if (done_o !== ((i - 2) >= 5))
                    $display("FAIL done_after_retire%0d: got %b expected %b", i - 2, done_o, (i - 2) >= 5);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (instr_count_o !== 32'd7 || err_o !== 1'b0)
            $display("FAIL done_count: got count=%0d err=%b expected 7 0", instr_count_o, err_o);
        else pass_cnt++;
        set_cap(1'b1, 32'h8000, trace_pkg::TYPE_R);
        retired_i = 1'b0;
        step(2);
        reset_n   = 1'b0;
        retired_i = 1'b1;
        #1;
        total_cnt++;
        if ({ret_valid_o, done_o, err_o, err_code_o} !== 5'b0 || instr_count_o !== 32'd0)
            $display("FAIL midreset_outputs: got valid=%b done=%b err=%b code=%b count=%0d expected all 0",
                     ret_valid_o, done_o, err_o, err_code_o, instr_count_o);
        else pass_cnt++;
        retired_i = 1'b0;
        set_cap(1'b0, '0, trace_pkg::TYPE_R);
        step(1);
        reset_n = 1'b1;
        step(4);
        total_cnt++;
        if (err_o !== 1'b0 || instr_count_o !== 32'd0 || done_o !== 1'b0)
            $display("FAIL midreset_discard: got err=%b count=%0d done=%b expected 0 0 0",
                     err_o, instr_count_o, done_o);
        else pass_cnt++;
        $display("test_done_and_reset done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_err_codes();
        test_done_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
